// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t : FSM state encodings (IDLE, SHIFT, DONE; 2'd3 is unused/illegal)
//   clog2   : ceiling log2, used to size the bit counter
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fullAdder.sv
// Single-bit full-adder cell.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one bit per clock through a single fullAdder
// cell plus a carry flip-flop, with a start/done handshake.
//   clk   : system clock (rising edge)
//   rst   : asynchronous reset, active-high
//   start : request pulse, accepted only in IDLE
//   a, b  : operands, sampled on the accepting edge
//   cin   : carry-in, sampled on the accepting edge
//   busy  : high while bits are being processed
//   done  : one-cycle pulse when sum/cout are updated
//   sum   : registered (a+b+cin) mod 2^WIDTH, held until the next result
//   cout  : registered carry-out of the MSB
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    fullAdder u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    // Built with a shift plus bit overwrite so WIDTH=1 needs no special case.
    always_comb begin
        sreg_next            = sreg >> 1;
        sreg_next[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            sreg    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa     <= a;
                        opb     <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    opa     <= opa >> 1;
                    opb     <= opb >> 1;
                    sreg    <= sreg_next;
                    carry_q <= fa_cout;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= sreg_next;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_checks;
    int n_fail;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vcin;
        logic [7:0] esum;
        logic       ecout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation from IDLE and wait (bounded) for done.
    // lat: negedges from the accepting edge until done seen (0 if never).
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vcin,
                          output int lat, output int busy_cyc, output bit stable);
        logic [7:0] prev_sum;
        logic       prev_cout;
        int cyc;
        @(negedge clk);
        start = 1'b1; a = va; b = vb; cin = vcin;
        prev_sum  = sum;
        prev_cout = cout;
        @(posedge clk);
        #1 start = 1'b0;
        a = ~va; b = ~vb; cin = ~vcin;
        lat = 0; busy_cyc = 0; stable = 1'b1; cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (done) begin
                lat = cyc;
                break;
            end
            if (sum !== prev_sum || cout !== prev_cout) stable = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int bc;
        bit stable;
        int dcount;
        logic [7:0] ca, cb, na, nb;
        logic       cc, nc;
        logic [8:0] full;
        logic [7:0] held_sum;
        logic       held_cout;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        start = 0; a = 0; b = 0; cin = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum",  32'(sum),  0);
        check("reset_cout", 32'(cout), 0);
        check("reset_busy_w1", 32'(busy1), 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, lat, bc, stable);
            check($sformatf("vec%0d_latency", i), 32'(lat), 9);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 8);
            check($sformatf("vec%0d_hold_prev", i), 32'(stable), 1);
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].esum));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].ecout));
            check($sformatf("vec%0d_busy_at_done", i), 32'(busy), 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), 32'(done), 0);
        end

        // start re-pulsed mid-operation must be ignored
        @(negedge clk);
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h55;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0;
        lat = 0;
        for (int c = 4; c <= 24; c++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                if (lat == 0) lat = c;
                if (dcount == 1) begin
                    check("repulse_sum", 32'(sum), 32'h10);
                    check("repulse_cout", 32'(cout), 0);
                end
            end
        end
        check("repulse_done_cycle", 32'(lat), 9);
        check("repulse_done_count", 32'(dcount), 1);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("prerst_busy", 32'(busy), 1);
        check("prerst_sum", 32'(sum), 32'h10);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_sum",  32'(sum),  0);
        check("midrst_cout", 32'(cout), 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("postrst_no_activity", 32'(dcount), 0);
        check("postrst_sum_held", 32'(sum), 0);
        run_op(8'h20, 8'h22, 1'b0, lat, bc, stable);
        check("postrst_latency", 32'(lat), 9);
        check("postrst_sum", 32'(sum), 32'h42);
        check("postrst_cout", 32'(cout), 0);

        // start held high: back-to-back operations every 10 cycles
        held_sum  = 8'h42;
        held_cout = 1'b0;
        @(negedge clk);
        ca = 8'($urandom_range(0, 255));
        cb = 8'($urandom_range(0, 255));
        cc = 1'($urandom_range(0, 1));
        start = 1'b1; a = ca; b = cb; cin = cc;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            na = 8'($urandom_range(0, 255));
            nb = 8'($urandom_range(0, 255));
            nc = 1'($urandom_range(0, 1));
            a = na; b = nb; cin = nc;
            full = 9'(ca) + 9'(cb) + 9'(cc);
            stable = 1'b1;
            dcount = 0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (done) dcount++;
                if (sum !== held_sum || cout !== held_cout) stable = 1'b0;
            end
            check($sformatf("stream%0d_early_done", k), 32'(dcount), 0);
            check($sformatf("stream%0d_sum_stable", k), 32'(stable), 1);
            @(negedge clk);
            check($sformatf("stream%0d_done", k), 32'(done), 1);
            check($sformatf("stream%0d_sum", k), 32'(sum), 32'(full[7:0]));
            check($sformatf("stream%0d_cout", k), 32'(cout), 32'(full[8]));
            held_sum  = full[7:0];
            held_cout = full[8];
            @(negedge clk);
            check($sformatf("stream%0d_done_drop", k), 32'(done), 0);
            ca = na; cb = nb; cc = nc;
            @(posedge clk);
        end
        #1 start = 1'b0;
        repeat (14) @(negedge clk);

        // WIDTH=1 instance
        @(negedge clk);
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        check("w1_busy", 32'(busy1), 1);
        check("w1_no_early_done", 32'(done1), 0);
        @(negedge clk);
        check("w1_done", 32'(done1), 1);
        check("w1_sum", 32'(sum1), 1);
        check("w1_cout", 32'(cout1), 1);
        @(negedge clk);
        check("w1_done_drop", 32'(done1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that processes one bit per clock through a single full-adder cell and a carry flip-flop.
- Sits directly upstream of the 1-bit fullAdder cell and drives it: each cycle it presents the operand LSBs and the stored carry, then captures sum and carry-out.
- Serves as the area-minimal sequential alternative to the ripple and lookahead adders in the lab datapath.
- Start/done handshake. Result is held stable until the next operation is accepted.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 1 and above.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  request pulse; accepted only in IDLE.
a  input  WIDTH  operand A; sampled on the accepting edge only.
b  input  WIDTH  operand B; sampled on the accepting edge only.
cin  input  1  carry-in; sampled on the accepting edge only.
busy  output  1  high while bits are being processed (SHIFT state).
done  output  1  single-cycle pulse; result is valid from this cycle on.
sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
cout  output  1  registered carry-out of the MSB.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0. Operand registers, carry flip-flop and bit counter are cleared. Reset takes effect immediately, including mid-operation. The aborted operation produces no done pulse and no result update.
- FSM states and encodings: IDLE (2'd0), SHIFT (2'd1), DONE (2'd2). Encoding 2'd3 is illegal and recovers to IDLE on the next edge.
- IDLE → SHIFT: start=1 at edge E.
  - a→opA, b→opB, cin→carry_q, counter=0.
  - busy rises after E.
- SHIFT, each edge:
  - The full-adder cell computes from opA[0], opB[0] and carry_q.
  - The sum bit shifts into the MSB of the internal shift register; the register shifts right.
  - opA and opB shift right with 0 fill.
  - carry_q takes the cell's carry-out; counter increments.
- SHIFT → DONE: on the edge where counter==WIDTH-1, i.e. the WIDTH-th SHIFT edge (E+WIDTH).
  - On that same edge, sum and cout load from the final shift register value and carry.
  - done=1 and busy=0 for exactly one cycle, following edge E+WIDTH.
- DONE → IDLE unconditionally on the next edge. done drops.
- Latency: done is high in the cycle after edge E+WIDTH, i.e. WIDTH+1 clocks after the accepting edge. Throughput is one add per WIDTH+2 cycles.
- sum and cout change only on the SHIFT→DONE edge or on reset. They hold the previous result throughout a new operation.
- start is ignored in SHIFT and DONE; no queuing. start held high continuously re-triggers each time IDLE is reached.
- a, b and cin may change freely after the accepting edge without affecting the result.
- Counter width is clog2(WIDTH), minimum 1 bit.
- WIDTH=1: SHIFT lasts exactly one cycle.
- No overflow flag. cout is the unsigned carry.

Decomposition:
- Shared include file holds:
  - state encodings: IDLE, SHIFT, DONE;
  - a clog2 function used for the counter width.
- Exactly one sub-module: the existing fullAdder cell, instantiated once. Ports map as a=opA[0], b=opB[0], cin=carry_q, giving cout and sum per bit.
- All sequencing (FSM, counter, shift registers) is flat in bit_serial_adder.

Test Plan:
1. WIDTH=8, a=0x0F, b=0x01, cin=0, start pulsed at edge E → busy high for 8 cycles; done high only in cycle after E+8; sum=0x10, cout=0.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
3. start re-pulsed at E+3 with a=0x55, b=0x55 during a 0x0F+0x01 operation → ignored; result 0x10/0 at E+8; no second done.
4. rst asserted at E+4 mid-operation, between clock edges → busy, done, sum and cout go to 0 immediately; no done pulse follows; a fresh 0x20+0x22 then yields 0x42/0.
5. start held high continuously; operands randomised after each accept → done every 10 cycles; each result matches the operands sampled at its accepting edge; sum is stable between done pulses.
6. WIDTH=1: a=1, b=1, cin=1 → done 2 cycles after accept; sum=1, cout=1.
